sudoku_stats: RTL and testbench

SUDOKU_STATS -- requirements
Module: sudoku_stats

---
 rtl/sudoku_stats_pkg.sv | 16 +
 rtl/sudoku_sat_cnt.sv | 26 ++
 rtl/sudoku_stats.sv | 153 +++++++++++++++
 tb/tb_sudoku_stats.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_stats_pkg.sv
// Shared constants for the sudoku solver statistics block: FSM state
// encodings and counter widths.
package sudoku_stats_pkg;

  localparam int HIST_BINS = 8;
  localparam int CNT_W     = 10;
  localparam int PERR_W    = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SOLVING = 2'd1;
  localparam state_t ST_CHECK   = 2'd2;
  localparam state_t ST_HUNG    = 2'd3;

endpackage

// File: rtl/sudoku_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sudoku_sat_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sudoku_stats.sv
// Solver statistics: event counts, latency min/max/sum, protocol errors and a watchdog.
// Define SUDOKU_STATS_HIST_EN to add an 8-bin latency histogram output (hist).
module sudoku_stats
  import sudoku_stats_pkg::*;
#(
  parameter int LAT_W   = 24,
  parameter int TIMEOUT = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              next_puzzle,
  input  logic              solution,
  input  logic              give_up,
  input  logic              match,
  output logic [CNT_W-1:0]  n_solved,
  output logic [CNT_W-1:0]  n_wrong,
  output logic [CNT_W-1:0]  n_gaveup,
  output logic [LAT_W-1:0]  min_lat,
  output logic [LAT_W-1:0]  max_lat,
  output logic [31:0]       sum_lat,
  output logic [PERR_W-1:0] proto_err,
  output logic              hung
`ifdef SUDOKU_STATS_HIST_EN
  ,
  output logic [HIST_BINS*CNT_W-1:0] hist
`endif
);

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [LAT_W-1:0]  lat_inc;
  logic [LAT_W-1:0]  min_q, min_d;
  logic [LAT_W-1:0]  max_q, max_d;
  logic [31:0]       sum_q, sum_d;
  logic              hung_q, hung_d;
  logic              inc_solved, inc_wrong, inc_gaveup, inc_perr;

  assign lat_inc = (&lat_q) ? lat_q : lat_q + LAT_W'(1);

  // In SOLVING, solution beats give_up beats a restart beats the watchdog.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    min_d      = min_q;
    max_d      = max_q;
    sum_d      = sum_q;
    hung_d     = hung_q;
    inc_solved = 1'b0;
    inc_wrong  = 1'b0;
    inc_gaveup = 1'b0;
    inc_perr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (solution || give_up) inc_perr = 1'b1;
        if (next_puzzle) begin
          state_d = ST_SOLVING;
          lat_d   = '0;
        end
      end
      ST_SOLVING: begin
        if (solution) begin
          state_d  = ST_CHECK;
          lat_d    = lat_inc;
          inc_perr = give_up;
        end else if (give_up) begin
          state_d    = ST_IDLE;
          lat_d      = '0;
          inc_gaveup = 1'b1;
        end else if (next_puzzle) begin
          lat_d    = '0;
          inc_perr = 1'b1;
        end else if (32'(lat_inc) >= TIMEOUT_W) begin
          state_d = ST_HUNG;
          lat_d   = lat_inc;
          hung_d  = 1'b1;
        end else begin
          lat_d = lat_inc;
        end
      end
      ST_CHECK: begin
        if (match) begin
          inc_solved = 1'b1;
          if (lat_q < min_q) min_d = lat_q;
          if (lat_q > max_q) max_d = lat_q;
          sum_d = sum_q + 32'(lat_q);
        end else begin
          inc_wrong = 1'b1;
        end
        if (next_puzzle) begin
          state_d = ST_SOLVING;
          lat_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      min_q   <= '1;
      max_q   <= '0;
      sum_q   <= '0;
      hung_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      min_q   <= min_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      hung_q  <= hung_d;
    end
  end

  sudoku_sat_cnt #(.W(CNT_W)) u_solved (
    .clk(clk), .clr(rst), .inc(inc_solved), .cnt(n_solved));
  sudoku_sat_cnt #(.W(CNT_W)) u_wrong (
    .clk(clk), .clr(rst), .inc(inc_wrong), .cnt(n_wrong));
  sudoku_sat_cnt #(.W(CNT_W)) u_gaveup (
    .clk(clk), .clr(rst), .inc(inc_gaveup), .cnt(n_gaveup));
  sudoku_sat_cnt #(.W(PERR_W)) u_perr (
    .clk(clk), .clr(rst), .inc(inc_perr), .cnt(proto_err));

`ifdef SUDOKU_STATS_HIST_EN
  localparam int HIST_SHIFT = LAT_W - 3;

  logic [LAT_W-1:0] lat_shr;
  logic [2:0]       hist_idx;

  assign lat_shr  = lat_q >> HIST_SHIFT;
  assign hist_idx = (lat_shr > LAT_W'(7)) ? 3'd7 : lat_shr[2:0];

  for (genvar b = 0; b < HIST_BINS; b++) begin : g_hist
    sudoku_sat_cnt #(.W(CNT_W)) u_bin (
      .clk(clk),
      .clr(rst),
      .inc(inc_solved && (hist_idx == 3'(b))),
      .cnt(hist[b*CNT_W +: CNT_W])
    );
  end
`endif

  assign min_lat = min_q;
  assign max_lat = max_q;
  assign sum_lat = sum_q;
  assign hung    = hung_q;

endmodule

// File: tb/tb_sudoku_stats.sv
// Directed self-checking bench for sudoku_stats (TIMEOUT=16); with
// SUDOKU_STATS_HIST_EN a second LAT_W=6 instance exercises the histogram.
module tb_sudoku_stats;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        next_puzzle = 1'b0;
  logic        solution = 1'b0;
  logic        give_up = 1'b0;
  logic        match = 1'b0;
  logic [9:0]  n_solved, n_wrong, n_gaveup;
  logic [23:0] min_lat, max_lat;
  logic [31:0] sum_lat;
  logic [7:0]  proto_err;
  logic        hung;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

`ifdef SUDOKU_STATS_HIST_EN
  logic [79:0] hist;
  logic [9:0]  h_solved, h_wrong, h_gaveup;
  logic [5:0]  h_min, h_max;
  logic [31:0] h_sum;
  logic [7:0]  h_perr;
  logic        h_hung;
  logic [79:0] h_hist;

  sudoku_stats #(.LAT_W(6), .TIMEOUT(1000)) dut_hist (
    .clk(clk), .rst(rst), .next_puzzle(next_puzzle), .solution(solution),
    .give_up(give_up), .match(match), .n_solved(h_solved), .n_wrong(h_wrong),
    .n_gaveup(h_gaveup), .min_lat(h_min), .max_lat(h_max), .sum_lat(h_sum),
    .proto_err(h_perr), .hung(h_hung), .hist(h_hist));
`endif

  sudoku_stats #(.LAT_W(24), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .next_puzzle(next_puzzle), .solution(solution),
    .give_up(give_up), .match(match), .n_solved(n_solved), .n_wrong(n_wrong),
    .n_gaveup(n_gaveup), .min_lat(min_lat), .max_lat(max_lat), .sum_lat(sum_lat),
    .proto_err(proto_err), .hung(hung)
`ifdef SUDOKU_STATS_HIST_EN
    , .hist(hist)
`endif
  );

  // One clock edge; inputs are changed and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; next_puzzle = 1'b0; solution = 1'b0; give_up = 1'b0; match = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Start a puzzle, present a solution lat cycles later, then give match result.
  task automatic run_puzzle(input int lat, input logic m);
    next_puzzle = 1'b1; tick(); next_puzzle = 1'b0;
    repeat (lat - 1) tick();
    solution = 1'b1; tick(); solution = 1'b0;
    match = m; tick(); match = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (n_solved !== 10'd0) begin n_fail++; $display("[TB] FAIL reset n_solved got %0d want 0", n_solved); end
    n_tests++; if (min_lat !== 24'hFFFFFF) begin n_fail++; $display("[TB] FAIL reset min_lat got %h want ffffff", min_lat); end
    n_tests++; if (max_lat !== 24'd0) begin n_fail++; $display("[TB] FAIL reset max_lat got %0d want 0", max_lat); end
    n_tests++; if (sum_lat !== 32'd0 || proto_err !== 8'd0 || hung !== 1'b0) begin n_fail++; $display("[TB] FAIL reset misc got sum=%0d perr=%0d hung=%b want 0/0/0", sum_lat, proto_err, hung); end
  endtask

  task automatic test_single();
    do_reset();
    next_puzzle = 1'b1; tick(); next_puzzle = 1'b0;
    repeat (4) tick();
    solution = 1'b1; tick(); solution = 1'b0;
    n_tests++; if (n_solved !== 10'd0) begin n_fail++; $display("[TB] FAIL single early n_solved got %0d want 0", n_solved); end
    match = 1'b1; tick(); match = 1'b0;
    n_tests++; if (n_solved !== 10'd1) begin n_fail++; $display("[TB] FAIL single n_solved got %0d want 1", n_solved); end
    n_tests++; if (min_lat !== 24'd5 || max_lat !== 24'd5) begin n_fail++; $display("[TB] FAIL single min/max got %0d/%0d want 5/5", min_lat, max_lat); end
    n_tests++; if (sum_lat !== 32'd5) begin n_fail++; $display("[TB] FAIL single sum_lat got %0d want 5", sum_lat); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    next_puzzle = 1'b1; tick(); next_puzzle = 1'b0;
    repeat (6) tick();
    solution = 1'b1; tick(); solution = 1'b0;
    match = 1'b1; next_puzzle = 1'b1; tick(); match = 1'b0; next_puzzle = 1'b0;
    repeat (2) tick();
    solution = 1'b1; tick(); solution = 1'b0;
    match = 1'b1; tick(); match = 1'b0;
    n_tests++; if (n_solved !== 10'd2) begin n_fail++; $display("[TB] FAIL b2b n_solved got %0d want 2", n_solved); end
    n_tests++; if (min_lat !== 24'd3) begin n_fail++; $display("[TB] FAIL b2b min_lat got %0d want 3", min_lat); end
    n_tests++; if (max_lat !== 24'd7) begin n_fail++; $display("[TB] FAIL b2b max_lat got %0d want 7", max_lat); end
    n_tests++; if (sum_lat !== 32'd10 || proto_err !== 8'd0) begin n_fail++; $display("[TB] FAIL b2b sum/perr got %0d/%0d want 10/0", sum_lat, proto_err); end
  endtask

  task automatic test_wrong_giveup();
    do_reset();
    run_puzzle(4, 1'b0);
    n_tests++; if (n_wrong !== 10'd1 || n_solved !== 10'd0) begin n_fail++; $display("[TB] FAIL wrong counts got wrong=%0d solved=%0d want 1/0", n_wrong, n_solved); end
    n_tests++; if (min_lat !== 24'hFFFFFF || max_lat !== 24'd0 || sum_lat !== 32'd0) begin n_fail++; $display("[TB] FAIL wrong stats got %h/%0d/%0d want ffffff/0/0", min_lat, max_lat, sum_lat); end
    next_puzzle = 1'b1; tick(); next_puzzle = 1'b0;
    repeat (2) tick();
    give_up = 1'b1; tick(); give_up = 1'b0;
    n_tests++; if (n_gaveup !== 10'd1 || proto_err !== 8'd0) begin n_fail++; $display("[TB] FAIL giveup got gaveup=%0d perr=%0d want 1/0", n_gaveup, proto_err); end
    // A solution after give_up lands in IDLE and is a protocol error.
    solution = 1'b1; tick(); solution = 1'b0;
    tick();
    n_tests++; if (proto_err !== 8'd1 || n_wrong !== 10'd1) begin n_fail++; $display("[TB] FAIL post-giveup got perr=%0d wrong=%0d want 1/1", proto_err, n_wrong); end
  endtask

  task automatic test_proto();
    do_reset();
    solution = 1'b1; tick(); solution = 1'b0;
    n_tests++; if (proto_err !== 8'd1) begin n_fail++; $display("[TB] FAIL proto idle got %0d want 1", proto_err); end
    next_puzzle = 1'b1; tick(); next_puzzle = 1'b0;
    repeat (2) tick();
    solution = 1'b1; give_up = 1'b1; tick(); solution = 1'b0; give_up = 1'b0;
    match = 1'b1; tick(); match = 1'b0;
    n_tests++; if (proto_err !== 8'd2) begin n_fail++; $display("[TB] FAIL proto both got %0d want 2", proto_err); end
    n_tests++; if (n_solved !== 10'd1 || n_gaveup !== 10'd0 || min_lat !== 24'd3) begin n_fail++; $display("[TB] FAIL proto counts got solved=%0d gaveup=%0d min=%0d want 1/0/3", n_solved, n_gaveup, min_lat); end
  endtask

  task automatic test_restart();
    do_reset();
    next_puzzle = 1'b1; tick(); next_puzzle = 1'b0;
    repeat (2) tick();
    next_puzzle = 1'b1; tick(); next_puzzle = 1'b0;
    tick();
    solution = 1'b1; tick(); solution = 1'b0;
    match = 1'b1; tick(); match = 1'b0;
    n_tests++; if (proto_err !== 8'd1 || min_lat !== 24'd2) begin n_fail++; $display("[TB] FAIL restart got perr=%0d lat=%0d want 1/2", proto_err, min_lat); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    next_puzzle = 1'b1; tick(); next_puzzle = 1'b0;
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    solution = 1'b1; tick(); solution = 1'b0;
    tick();
    n_tests++; if (proto_err !== 8'd1 || n_wrong !== 10'd0) begin n_fail++; $display("[TB] FAIL reset_mid got perr=%0d wrong=%0d want 1/0", proto_err, n_wrong); end
  endtask

  task automatic test_watchdog();
    do_reset();
    next_puzzle = 1'b1; tick(); next_puzzle = 1'b0;
    repeat (15) tick();
    n_tests++; if (hung !== 1'b0) begin n_fail++; $display("[TB] FAIL watchdog early hung got %b want 0", hung); end
    tick();
    n_tests++; if (hung !== 1'b1) begin n_fail++; $display("[TB] FAIL watchdog hung got %b want 1", hung); end
    solution = 1'b1; tick(); solution = 1'b0;
    match = 1'b1; tick(); match = 1'b0;
    give_up = 1'b1; tick(); give_up = 1'b0;
    n_tests++; if (n_solved !== 10'd0 || n_wrong !== 10'd0 || proto_err !== 8'd0 || hung !== 1'b1) begin n_fail++; $display("[TB] FAIL watchdog ignore got s=%0d w=%0d perr=%0d hung=%b want 0/0/0/1", n_solved, n_wrong, proto_err, hung); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_tests++; if (hung !== 1'b0 || n_gaveup !== 10'd0 || max_lat !== 24'd0) begin n_fail++; $display("[TB] FAIL watchdog rst got hung=%b gaveup=%0d max=%0d want 0/0/0", hung, n_gaveup, max_lat); end
    run_puzzle(2, 1'b1);
    n_tests++; if (n_solved !== 10'd1 || min_lat !== 24'd2) begin n_fail++; $display("[TB] FAIL watchdog recover got s=%0d min=%0d want 1/2", n_solved, min_lat); end
  endtask

  task automatic test_saturate();
    do_reset();
    solution = 1'b1;
    repeat (254) tick();
    n_tests++; if (proto_err !== 8'd254) begin n_fail++; $display("[TB] FAIL sat pre got %0d want 254", proto_err); end
    repeat (6) tick();
    solution = 1'b0;
    n_tests++; if (proto_err !== 8'd255) begin n_fail++; $display("[TB] FAIL sat got %0d want 255", proto_err); end
  endtask

`ifdef SUDOKU_STATS_HIST_EN
  task automatic test_hist();
    logic [9:0] want;
    do_reset();
    run_puzzle(2, 1'b1);
    run_puzzle(9, 1'b1);
    run_puzzle(63, 1'b1);
    run_puzzle(5, 1'b0);
    for (int b = 0; b < 8; b++) begin
      want = (b == 0 || b == 1 || b == 7) ? 10'd1 : 10'd0;
      n_tests++;
      if (h_hist[b*10 +: 10] !== want) begin
        n_fail++;
        $display("[TB] FAIL hist bin%0d got %0d want %0d", b, h_hist[b*10 +: 10], want);
      end
    end
    n_tests++; if (h_min !== 6'd2 || h_max !== 6'd63 || h_sum !== 32'd74) begin n_fail++; $display("[TB] FAIL hist stats got %0d/%0d/%0d want 2/63/74", h_min, h_max, h_sum); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrong_giveup();
    test_proto();
    test_restart();
    test_reset_mid();
    test_watchdog();
    test_saturate();
`ifdef SUDOKU_STATS_HIST_EN
    test_hist();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
